univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: multi-lane serial in/out, parallel load, and six

---
 rtl/usr_pkg.sv | 14 +
 rtl/usr_step.sv | 46 ++++
 rtl/univ_shift_reg.sv | 87 ++++++++
 tb/tb_univ_shift_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: step modes and run-FSM states.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ASR  = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/usr_step.sv
// One shift/rotate step of the register. Pure combinational; shared by run and manual paths.
module usr_step #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic [WIDTH-1:0] r,
    input  logic [LANES-1:0] sin,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] next_r,
    output logic [LANES-1:0] sout
);
    import usr_pkg::*;

    // Next register value and the lanes that leave on this step; reserved modes hold
    always_comb begin
        next_r = r;
        sout   = '0;
        case (mode)
            MODE_SHL: begin
                next_r = {r[WIDTH-LANES-1:0], sin};
                sout   = r[WIDTH-1 -: LANES];
            end
            MODE_SHR: begin
                next_r = {sin, r[WIDTH-1:LANES]};
                sout   = r[LANES-1:0];
            end
            MODE_ROL: begin
                next_r = {r[WIDTH-LANES-1:0], r[WIDTH-1 -: LANES]};
                sout   = r[WIDTH-1 -: LANES];
            end
            MODE_ROR: begin
                next_r = {r[LANES-1:0], r[WIDTH-1:LANES]};
                sout   = r[LANES-1:0];
            end
            MODE_ASR: begin
                next_r = {{LANES{r[WIDTH-1]}}, r[WIDTH-1:LANES]};
                sout   = r[LANES-1:0];
            end
            default: begin
                next_r = r;
                sout   = '0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, manual stepping and an autonomous N-step run.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | waiting; load, start or manual en step accepted
//  ST_RUN  | one step per edge with the latched mode until cnt reaches 1
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [LANES-1:0] sin,
    input  logic             load,
    input  logic [WIDTH-1:0] pdin,
    input  logic             start,
    input  logic [CNTW-1:0]  nsteps,
    output logic [WIDTH-1:0] pout,
    output logic [LANES-1:0] sout,
    output logic             busy,
    output logic             done
);
    import usr_pkg::*;

    logic [0:0]      state;
    logic [CNTW-1:0] cnt;
    logic [2:0]      run_mode;
    logic [2:0]      act_mode;
    logic [WIDTH-1:0] step_r;

    // While running the latched mode drives the step logic; the live input is ignored
    assign act_mode = (state == ST_RUN) ? run_mode : mode;

    usr_step #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_step (
        .r      (pout),
        .sin    (sin),
        .mode   (act_mode),
        .next_r (step_r),
        .sout   (sout)
    );

    // Priority: rst > load > run step > start > manual step; done is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            run_mode <= MODE_HOLD;
            pout     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                pout  <= pdin;
                state <= ST_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                pout <= step_r;
                cnt  <= cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (start) begin
                if (nsteps != '0) begin
                    state    <= ST_RUN;
                    run_mode <= mode;
                    cnt      <= nsteps;
                    busy     <= 1'b1;
                end else begin
                    done <= 1'b1;
                end
            end else if (en) begin
                pout <= step_r;
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench: one DUT with LANES=1 and one with LANES=2 sharing control inputs.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, en, load, start;
    logic [2:0] mode;
    logic [7:0] pdin;
    logic [3:0] nsteps;
    logic [0:0] sin1;
    logic [1:0] sin2;
    logic [7:0] pout1, pout2;
    logic [0:0] sout1;
    logic [1:0] sout2;
    logic       busy1, done1, busy2, done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .LANES(1), .CNTW(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin1), .load(load),
        .pdin(pdin), .start(start), .nsteps(nsteps),
        .pout(pout1), .sout(sout1), .busy(busy1), .done(done1)
    );

    univ_shift_reg #(.WIDTH(8), .LANES(2), .CNTW(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin2), .load(load),
        .pdin(pdin), .start(start), .nsteps(nsteps),
        .pout(pout2), .sout(sout2), .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; pdin = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (pout1 !== 8'h00) begin errors++; $display("FAIL reset_pout1 got %h exp 00", pout1); end
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
        checks++; if (done1 !== 1'b0)  begin errors++; $display("FAIL reset_done1 got %b exp 0", done1); end
        checks++; if (sout1 !== 1'b0)  begin errors++; $display("FAIL reset_sout1 got %b exp 0", sout1); end
        checks++; if (pout2 !== 8'h00) begin errors++; $display("FAIL reset_pout2 got %h exp 00", pout2); end
    endtask

    task automatic test_manual_shl();
        do_load(8'hA5);
        checks++; if (pout1 !== 8'hA5) begin errors++; $display("FAIL load_a5 got %h exp a5", pout1); end
        mode = 3'd1; sin1 = 1'b1; en = 1'b1;
        #1;
        checks++; if (sout1 !== 1'b1) begin errors++; $display("FAIL shl_sout_pre got %b exp 1", sout1); end
        tick();
        checks++; if (pout1 !== 8'h4B) begin errors++; $display("FAIL shl_step1 got %h exp 4b", pout1); end
        tick();
        tick();
        en = 1'b0;
        checks++; if (pout1 !== 8'h2F) begin errors++; $display("FAIL shl_step3 got %h exp 2f", pout1); end
        checks++; if (done1 !== 1'b0)  begin errors++; $display("FAIL shl_done got %b exp 0", done1); end
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL shl_busy got %b exp 0", busy1); end
    endtask

    task automatic test_run_rol();
        logic [7:0] exp_p [3] = '{8'h03, 8'h06, 8'h0C};
        int busy_cycles = 0;
        mode = 3'd0;
        do_load(8'h81);
        mode = 3'd3; nsteps = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy1 !== 1'b1 || pout1 !== 8'h81) begin errors++; $display("FAIL rol_start got busy=%b pout=%h exp busy=1 pout=81", busy1, pout1); end
        checks++; if (sout1 !== 1'b1) begin errors++; $display("FAIL rol_sout got %b exp 1", sout1); end
        for (int i = 0; i < 3; i++) begin
            if (busy1 === 1'b1) busy_cycles++;
            tick();
            checks++; if (pout1 !== exp_p[i]) begin errors++; $display("FAIL rol_step%0d got %h exp %h", i + 1, pout1, exp_p[i]); end
            checks++; if (done1 !== (i == 2)) begin errors++; $display("FAIL rol_done%0d got %b exp %b", i + 1, done1, (i == 2)); end
        end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL rol_busy_cycles got %0d exp 3", busy_cycles); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rol_busy_end got %b exp 0", busy1); end
        tick();
        checks++; if (done1 !== 1'b0 || pout1 !== 8'h0C) begin errors++; $display("FAIL rol_after got done=%b pout=%h exp done=0 pout=0c", done1, pout1); end
    endtask

    task automatic test_run_asr();
        mode = 3'd0;
        do_load(8'h90);
        mode = 3'd5; nsteps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'd1; en = 1'b1; sin1 = 1'b0;
        tick();
        checks++; if (pout1 !== 8'hC8) begin errors++; $display("FAIL asr_step1 got %h exp c8", pout1); end
        mode = 3'd4;
        tick();
        en = 1'b0; mode = 3'd0;
        checks++; if (pout1 !== 8'hE4) begin errors++; $display("FAIL asr_step2 got %h exp e4", pout1); end
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL asr_end got done=%b busy=%b exp done=1 busy=0", done1, busy1); end
    endtask

    task automatic test_zero_steps();
        mode = 3'd1; nsteps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy1); end
        checks++; if (pout1 !== 8'hE4) begin errors++; $display("FAIL zero_pout got %h exp e4", pout1); end
        tick();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL zero_done_clear got %b exp 0", done1); end
    endtask

    task automatic test_load_mid_run();
        mode = 3'd0;
        do_load(8'h01);
        mode = 3'd1; sin1 = 1'b0; nsteps = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (pout1 !== 8'h02) begin errors++; $display("FAIL abort_step1 got %h exp 02", pout1); end
        load = 1'b1; pdin = 8'hFF;
        tick();
        load = 1'b0;
        checks++; if (pout1 !== 8'hFF || busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL abort_load got pout=%h busy=%b done=%b exp ff 0 0", pout1, busy1, done1); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (done1 !== 1'b0 || pout1 !== 8'hFF) begin errors++; $display("FAIL abort_after%0d got done=%b pout=%h exp 0 ff", i, done1, pout1); end
        end
    endtask

    task automatic test_rst_mid_run();
        mode = 3'd0;
        do_load(8'h55);
        mode = 3'd4; nsteps = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (pout1 !== 8'hAA) begin errors++; $display("FAIL rst_run_step1 got %h exp aa", pout1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pout1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0 || sout1 !== 1'b0) begin errors++; $display("FAIL rst_mid got pout=%h busy=%b done=%b sout=%b exp 0", pout1, busy1, done1, sout1); end
        tick();
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rst_after got busy=%b done=%b exp 0 0", busy1, done1); end
    endtask

    task automatic test_lanes2();
        mode = 3'd0;
        do_load(8'hC3);
        mode = 3'd4; nsteps = 4'd1; start = 1'b1;
        #1;
        checks++; if (sout2 !== 2'b11) begin errors++; $display("FAIL l2_sout_pre got %b exp 11", sout2); end
        tick();
        start = 1'b0; mode = 3'd0;
        checks++; if (busy2 !== 1'b1 || sout2 !== 2'b11) begin errors++; $display("FAIL l2_run got busy=%b sout=%b exp 1 11", busy2, sout2); end
        tick();
        checks++; if (pout2 !== 8'hF0) begin errors++; $display("FAIL l2_ror got %h exp f0", pout2); end
        checks++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL l2_ror_end got done=%b busy=%b exp 1 0", done2, busy2); end
        do_load(8'h00);
        mode = 3'd2; sin2 = 2'b10; en = 1'b1;
        tick();
        checks++; if (pout2 !== 8'h80) begin errors++; $display("FAIL l2_shr1 got %h exp 80", pout2); end
        tick();
        en = 1'b0;
        checks++; if (pout2 !== 8'hA0) begin errors++; $display("FAIL l2_shr2 got %h exp a0", pout2); end
        mode = 3'd6; en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (pout2 !== 8'hA0 || sout2 !== 2'b00) begin errors++; $display("FAIL l2_reserved got pout=%h sout=%b exp a0 00", pout2, sout2); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0;
        mode = 3'd0; pdin = 8'h00; nsteps = 4'd0; sin1 = 1'b0; sin2 = 2'b00;
        test_reset();
        test_manual_shl();
        test_run_rol();
        test_run_asr();
        test_zero_steps();
        test_load_mid_run();
        test_rst_mid_run();
        test_lanes2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
